// File: rtl/hack_rom_loader_pkg.sv
// Shared types and constants for the Hack ROM loader slice.
package hack_pkg;

    localparam int HACK_WORD_W = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LEN_HI  = 3'd1,
        LEN_LO  = 3'd2,
        DATA_HI = 3'd3,
        DATA_LO = 3'd4,
        CHECK   = 3'd5,
        DONE    = 3'd6,
        ERR     = 3'd7
    } loader_state_t;

    function automatic logic [7:0] chk_step(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/hack_rom_loader_if.sv
// Host byte stream, ROM write port and CPU control/status bundle of the loader.
interface hack_rom_loader_if #(
    parameter int ADDR_W = 15
);
    import hack_pkg::*;

    logic                   load_req_i;
    logic [7:0]             byte_i;
    logic                   byte_valid_i;
    logic                   byte_ready_o;
    logic                   wr_en_o;
    logic [ADDR_W-1:0]      wr_addr_o;
    logic [HACK_WORD_W-1:0] wr_data_o;
    logic                   cpu_rst_o;
    logic                   busy_o;
    logic                   done_o;
    logic                   err_o;

    modport master (
        output load_req_i, byte_i, byte_valid_i,
        input  byte_ready_o, wr_en_o, wr_addr_o, wr_data_o,
               cpu_rst_o, busy_o, done_o, err_o
    );

    modport slave (
        input  load_req_i, byte_i, byte_valid_i,
        output byte_ready_o, wr_en_o, wr_addr_o, wr_data_o,
               cpu_rst_o, busy_o, done_o, err_o
    );

endinterface

// File: rtl/hack_rom_loader_byte_packer.sv
// Joins the HI/LO stream bytes into one Hack word and issues a registered write strobe.
module hack_byte_packer
    import hack_pkg::*;
#(
    parameter int ADDR_W = 15
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   hi_en,
    input  logic                   lo_en,
    input  logic [7:0]             din,
    input  logic [ADDR_W-1:0]      addr,
    output logic                   wr_en,
    output logic [ADDR_W-1:0]      wr_addr,
    output logic [HACK_WORD_W-1:0] wr_data
);

    logic [7:0] hi_q;

    // Address/data only move on a write, so they hold between strobes.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            hi_q    <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= lo_en;
            if (hi_en)
                hi_q <= din;
            if (lo_en) begin
                wr_addr <= addr;
                wr_data <= {hi_q, din};
            end
        end
    end

endmodule

// File: rtl/hack_rom_loader.sv
// Hack ROM loader: parses LEN/DATA/CHK frames from a byte stream, writes the ROM, holds the CPU meanwhile.
module hack_rom_loader
    import hack_pkg::*;
#(
    parameter int ADDR_W   = 15,
    parameter bit CPU_HOLD = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    hack_rom_loader_if.slave  bus
);

    localparam logic [16:0] CAP = 17'(1) << ADDR_W;

    localparam logic [2:0] S_IDLE    = 3'(IDLE);
    localparam logic [2:0] S_LEN_HI  = 3'(LEN_HI);
    localparam logic [2:0] S_LEN_LO  = 3'(LEN_LO);
    localparam logic [2:0] S_DATA_HI = 3'(DATA_HI);
    localparam logic [2:0] S_DATA_LO = 3'(DATA_LO);
    localparam logic [2:0] S_CHECK   = 3'(CHECK);
    localparam logic [2:0] S_DONE    = 3'(DONE);
    localparam logic [2:0] S_ERR     = 3'(ERR);

    logic [2:0]             state;
    logic [7:0]             len_hi;
    logic [7:0]             chk;
    logic [ADDR_W:0]        len_q;
    logic [ADDR_W:0]        cnt;
    logic                   cpu_rst_q;
    logic                   done_q;
    logic                   err_q;
    logic                   ready;
    logic                   busy;
    logic                   accept;
    logic [16:0]            len_n;
    logic [ADDR_W:0]        cnt_nxt;
    logic                   wr_en;
    logic [ADDR_W-1:0]      wr_addr;
    logic [HACK_WORD_W-1:0] wr_data;

    assign ready   = (state == S_LEN_HI) || (state == S_LEN_LO) || (state == S_DATA_HI) ||
                     (state == S_DATA_LO) || (state == S_CHECK);
    assign busy    = !((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));
    assign accept  = bus.byte_valid_i & ready;
    assign len_n   = {1'b0, len_hi, bus.byte_i};
    assign cnt_nxt = cnt + (ADDR_W+1)'(1);

    // Counter is one bit wider than the address so a full-ROM load terminates cleanly.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state     <= S_IDLE;
            len_hi    <= '0;
            chk       <= '0;
            len_q     <= '0;
            cnt       <= '0;
            cpu_rst_q <= CPU_HOLD;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (bus.load_req_i) begin
                        state     <= S_LEN_HI;
                        chk       <= '0;
                        cnt       <= '0;
                        cpu_rst_q <= CPU_HOLD;
                        done_q    <= 1'b0;
                        err_q     <= 1'b0;
                    end
                end
                S_LEN_HI: begin
                    if (accept) begin
                        len_hi <= bus.byte_i;
                        chk    <= chk_step(chk, bus.byte_i);
                        state  <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (accept) begin
                        chk   <= chk_step(chk, bus.byte_i);
                        len_q <= len_n[ADDR_W:0];
                        if (len_n > CAP) begin
                            state <= S_ERR;
                            err_q <= 1'b1;
                        end else if (len_n == 17'd0) begin
                            state <= S_CHECK;
                        end else begin
                            state <= S_DATA_HI;
                        end
                    end
                end
                S_DATA_HI: begin
                    if (accept) begin
                        chk   <= chk_step(chk, bus.byte_i);
                        state <= S_DATA_LO;
                    end
                end
                S_DATA_LO: begin
                    if (accept) begin
                        chk   <= chk_step(chk, bus.byte_i);
                        cnt   <= cnt_nxt;
                        state <= (cnt_nxt == len_q) ? S_CHECK : S_DATA_HI;
                    end
                end
                S_CHECK: begin
                    if (accept) begin
                        if (bus.byte_i == chk) begin
                            state     <= S_DONE;
                            done_q    <= 1'b1;
                            cpu_rst_q <= 1'b0;
                        end else begin
                            state <= S_ERR;
                            err_q <= 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    hack_byte_packer #(
        .ADDR_W (ADDR_W)
    ) u_packer (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .hi_en   (accept && (state == S_DATA_HI)),
        .lo_en   (accept && (state == S_DATA_LO)),
        .din     (bus.byte_i),
        .addr    (cnt[ADDR_W-1:0]),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

    assign bus.byte_ready_o = ready;
    assign bus.busy_o       = busy;
    assign bus.wr_en_o      = wr_en;
    assign bus.wr_addr_o    = wr_addr;
    assign bus.wr_data_o    = wr_data;
    assign bus.cpu_rst_o    = cpu_rst_q;
    assign bus.done_o       = done_q;
    assign bus.err_o        = err_q;

endmodule
